// File: rtl/toggle_dec_pkg.sv
// Shared types and default constants for the toggle-encoded event decoder.
// State encoding is fixed so that other blocks can decode the busy state.
package toggle_dec_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      QUAL  = 2'd1,
      BLANK = 2'd2
   } state_t;

   localparam int CNT_W_DEF       = 8;
   localparam int GAP_CYCLES_DEF  = 4;
   localparam int FILT_CYCLES_DEF = 3;

endpackage

// File: rtl/sync2_ff.sv
// Two-flop synchroniser for a single asynchronous level.
// Synchronous active-high reset clears both stages.
module sync2_ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic s1;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= 1'b0;
         q  <= 1'b0;
      end else begin
         s1 <= d;
         q  <= s1;
      end
   end

endmodule

// File: rtl/toggle_event_decoder.sv
// Toggle-line event decoder with saturating pending count and valid/ready drain.
// Optional glitch filter (QUAL state) enabled by TOGGLE_DEC_GLITCH_FILTER_EN.
module toggle_event_decoder
   import toggle_dec_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int GAP_CYCLES  = GAP_CYCLES_DEF
`ifdef TOGGLE_DEC_GLITCH_FILTER_EN
  ,parameter int FILT_CYCLES = FILT_CYCLES_DEF
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tog_in,
   output logic             ev_pulse,
   output logic             ev_valid,
   input  logic             ev_ready,
   output logic [CNT_W-1:0] ev_count,
   output logic             overflow,
   output logic             busy
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [7:0]       GAP_LD  = 8'(GAP_CYCLES - 1);

   state_t           state, state_n;
   logic             sync2;
   logic             ref_lvl, ref_n;
   logic [1:0]       init_cnt;
   logic             init_done;
   logic [7:0]       gap_cnt, gap_n;
   logic             diff;
   logic             accept;
   logic             hs;
   logic [CNT_W-1:0] cnt_n;
   logic             ovf_n;
`ifdef TOGGLE_DEC_GLITCH_FILTER_EN
   logic [7:0]       filt_cnt, filt_n;
`endif

   sync2_ff u_sync (
      .clk (clk),
      .rst (rst),
      .d   (tog_in),
      .q   (sync2)
   );

   // ref_lvl tracks sync2 until the synchroniser has flushed the reset
   // zeros, so a line already high at reset release is never counted.
   assign init_done = (init_cnt == 2'd3);
   assign diff      = (sync2 != ref_lvl);
   assign hs        = ev_valid & ev_ready;
   assign busy      = (state != IDLE);

   always_comb begin
      state_n = state;
      gap_n   = gap_cnt;
      ref_n   = ref_lvl;
      accept  = 1'b0;
`ifdef TOGGLE_DEC_GLITCH_FILTER_EN
      filt_n  = filt_cnt;
`endif
      if (!init_done) begin
         ref_n = sync2;
      end else begin
         unique case (state)
            IDLE: begin
               if (diff) begin
`ifdef TOGGLE_DEC_GLITCH_FILTER_EN
                  state_n = QUAL;
                  filt_n  = 8'd1;
`else
                  accept  = 1'b1;
`endif
               end
            end
`ifdef TOGGLE_DEC_GLITCH_FILTER_EN
            QUAL: begin
               if (!diff)
                  state_n = IDLE;
               else if (filt_cnt >= 8'(FILT_CYCLES))
                  accept = 1'b1;
               else
                  filt_n = filt_cnt + 8'd1;
            end
`endif
            BLANK: begin
               if (gap_cnt == 8'd0)
                  state_n = IDLE;
               else
                  gap_n = gap_cnt - 8'd1;
            end
            default: state_n = IDLE;
         endcase
      end
      if (accept) begin
         ref_n   = sync2;
         gap_n   = GAP_LD;
         state_n = BLANK;
`ifdef TOGGLE_DEC_GLITCH_FILTER_EN
         filt_n  = 8'd0;
`endif
      end
   end

   // The consumer sees the pre-increment value on a handshake edge.
   always_comb begin
      cnt_n = ev_count;
      ovf_n = overflow;
      if (accept && hs)
         cnt_n = CNT_W'(1);
      else if (accept) begin
         if (ev_count == CNT_MAX)
            ovf_n = 1'b1;
         else
            cnt_n = ev_count + CNT_W'(1);
      end else if (hs)
         cnt_n = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         ref_lvl  <= 1'b0;
         init_cnt <= 2'd0;
         gap_cnt  <= 8'd0;
         ev_pulse <= 1'b0;
         ev_count <= '0;
         ev_valid <= 1'b0;
         overflow <= 1'b0;
      end else begin
         state    <= state_n;
         ref_lvl  <= ref_n;
         gap_cnt  <= gap_n;
         ev_pulse <= accept;
         ev_count <= cnt_n;
         ev_valid <= (cnt_n != '0);
         overflow <= ovf_n;
         if (!init_done)
            init_cnt <= init_cnt + 2'd1;
      end
   end

`ifdef TOGGLE_DEC_GLITCH_FILTER_EN
   always_ff @(posedge clk) begin
      if (rst)
         filt_cnt <= 8'd0;
      else
         filt_cnt <= filt_n;
   end
`endif

endmodule

// File: tb/tb_toggle_event_decoder.sv
// Self-checking bench: event-time model compared every cycle plus
// directed literal checks on latency, blanking, saturation and handshake.
module tb_toggle_event_decoder;

   localparam int TB_CNT_W = 2;
   localparam int GAP      = 4;
   localparam int MAXC     = (1 << TB_CNT_W) - 1;
`ifdef TOGGLE_DEC_GLITCH_FILTER_EN
   localparam int FILT     = 3;
`else
   localparam int FILT     = 0;
`endif
   localparam int LAT      = 2 + FILT;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                tog_in = 1'b1;
   logic                ev_ready = 1'b0;
   logic                ev_pulse;
   logic                ev_valid;
   logic [TB_CNT_W-1:0] ev_count;
   logic                overflow;
   logic                busy;

   toggle_event_decoder #(
      .CNT_W      (TB_CNT_W),
      .GAP_CYCLES (GAP)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .tog_in   (tog_in),
      .ev_pulse (ev_pulse),
      .ev_valid (ev_valid),
      .ev_ready (ev_ready),
      .ev_count (ev_count),
      .overflow (overflow),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp)
         passed++;
      else
         $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
   endtask

   // Model state: edge index, synchroniser copy, event timestamps
   int cyc = 0;
   bit s1m, s2m, refm, pm, ovfm, busym, evm, dm, hsm;
   int initm, lastev, qs, cntm;

   initial begin
      s1m = 0; s2m = 0; refm = 0; pm = 0; ovfm = 0; busym = 0;
      initm = 0; lastev = -1000; qs = -1; cntm = 0;
      forever begin
         @(posedge clk);
         cyc++;
         if (rst) begin
            s1m = 0; s2m = 0; refm = 0; initm = 0;
            lastev = -1000; qs = -1; cntm = 0; ovfm = 0; pm = 0;
         end else begin
            evm = 0;
            dm  = (s2m != refm);
            hsm = (cntm != 0) && ev_ready;
            if (initm < 3) begin
               refm = s2m;
               initm++;
            end else if (cyc - lastev > GAP) begin
               if (FILT == 0)
                  evm = dm;
               else if (qs < 0) begin
                  if (dm) qs = cyc;
               end else if (!dm)
                  qs = -1;
               else if (cyc - qs >= FILT)
                  evm = 1;
            end
            if (evm) begin
               refm = s2m;
               lastev = cyc;
               qs = -1;
            end
            if (evm && hsm)
               cntm = 1;
            else if (evm) begin
               if (cntm == MAXC) ovfm = 1;
               else cntm++;
            end else if (hsm)
               cntm = 0;
            pm  = evm;
            s2m = s1m;
            s1m = tog_in;
         end
         busym = !rst && ((cyc - lastev < GAP) || qs >= 0);
      end
   end

   int pe[$];
   int npulse = 0;

   initial begin
      forever begin
         @(negedge clk);
         if (cyc > 0) begin
            chk("pulse",    int'(ev_pulse), int'(pm));
            chk("count",    int'(ev_count), cntm);
            chk("valid",    int'(ev_valid), int'(cntm != 0));
            chk("overflow", int'(overflow), int'(ovfm));
            chk("busy",     int'(busy),     int'(busym));
            if (ev_pulse) begin
               pe.push_back(cyc);
               npulse++;
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain();
      ev_ready = 1'b1;
      tick(1);
      ev_ready = 1'b0;
   endtask

   int k, np0, hv;

   initial begin
      // reset with the line already high
      rst = 1'b1; tog_in = 1'b1;
      tick(3);
      rst = 1'b0;
      tick(10);
      chk("rst_pulses", npulse, 0);
      chk("rst_count", int'(ev_count), 0);
      chk("rst_valid", int'(ev_valid), 0);

      // single toggle
      np0 = npulse;
      tog_in = ~tog_in; k = cyc + 1;
      tick(10);
      chk("single_n", npulse - np0, 1);
      chk("single_lat", pe[$], k + LAT);
      chk("single_count", int'(ev_count), 1);
      chk("single_valid", int'(ev_valid), 1);

      // handshake coinciding with an event
      tog_in = ~tog_in;
      tick(10);
      chk("pre_hs_count", int'(ev_count), 2);
      tog_in = ~tog_in; k = cyc + 1;
      tick(1 + LAT - 1);
      ev_ready = 1'b1;
      @(negedge clk);
      hv = int'(ev_count);
      chk("hs_value", hv, 2);
      tick(1);
      ev_ready = 1'b0;
      chk("hs_pulse", int'(ev_pulse), 1);
      chk("hs_after", int'(ev_count), 1);
      chk("hs_valid", int'(ev_valid), 1);
      tick(8);

      // event then a toggle pair inside the blank window
      np0 = npulse;
      tog_in = ~tog_in; tick(2);
      tog_in = ~tog_in; tick(2);
      tog_in = ~tog_in;
      tick(15);
      chk("pair_n", npulse - np0, 1);
      chk("pair_count", int'(ev_count), 2);
      drain();
      chk("drain_count", int'(ev_count), 0);
      chk("drain_valid", int'(ev_valid), 0);

      // single toggle inside blanking is deferred
      np0 = npulse;
      tog_in = ~tog_in; tick(2);
      tog_in = ~tog_in;
      tick(15);
      chk("defer_n", npulse - np0, 2);
      chk("defer_gap", pe[$] - pe[$-1], GAP + 1);
      chk("defer_count", int'(ev_count), 2);
      drain();

      // saturation at 3
      for (int i = 0; i < 5; i++) begin
         tog_in = ~tog_in;
         tick(10);
         if (i == 2) begin
            chk("sat3_count", int'(ev_count), 3);
            chk("sat3_ovf", int'(overflow), 0);
         end
         if (i == 3) chk("sat4_ovf", int'(overflow), 1);
      end
      chk("sat_count", int'(ev_count), MAXC);
      chk("sat_ovf", int'(overflow), 1);
      drain();
      chk("sat_drain", int'(ev_count), 0);
      chk("sat_sticky", int'(overflow), 1);

      // reset mid-blanking
      tog_in = ~tog_in;
      tick(LAT + 1);
      chk("mid_busy", int'(busy), 1);
      chk("mid_count", int'(ev_count), 1);
      rst = 1'b1; tick(1); rst = 1'b0;
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_count", int'(ev_count), 0);
      chk("mid_rst_ovf", int'(overflow), 0);
      tick(1);
      np0 = npulse;
      tick(10);
      chk("mid_rst_n", npulse - np0, 0);

`ifdef TOGGLE_DEC_GLITCH_FILTER_EN
      np0 = npulse;
      tog_in = ~tog_in; tick(2);
      tog_in = ~tog_in;
      tick(10);
      chk("glitch_n", npulse - np0, 0);
      chk("glitch_busy", int'(busy), 0);
      tog_in = ~tog_in; k = cyc + 1;
      tick(12);
      chk("filt_n", npulse - np0, 1);
      chk("filt_lat", pe[$], k + 5);
`endif

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
